regfile_dump_ctrl: RTL and testbench
====================================

# regfile_dump_ctrl

Read-side sequencer for the 32x32 register file: on a start pulse it walks a range of register indices over one asynchronous read port, captures each value, and streams (index, data) beats out over a valid/ready handshake. It sits beside the RISC-V core's `RegFile` as a debug/checkpoint reader. It owns one read-address mux input while `busy` is high, and the core is held stalled by the owner of `busy`. It never writes the register file.

## Interface
Parameters:
- `NREGS`, 32, number of registers; must be a power of two.
- `AW`, 5, index width; log2(`NREGS`).
- `DW`, 32, data width.

Ports:
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  one-cycle request; sampled only in IDLE.
- `abort`  in  1  cancels a dump in progress; sampled only in RUN.
- `first_reg`  in  AW  first index to dump; sampled with `start`.
- `last_reg`  in  AW  last index to dump, inclusive; sampled with `start`.
- `ra`  out  AW  read address to the register file read port.
- `rd`  in  DW  combinational read data from the register file for `ra`.
- `out_valid`  out  1  beat valid.
- `out_ready`  in  1  sink accepts the beat.
- `out_addr`  out  AW  index of the current beat.
- `out_data`  out  DW  register value of the current beat.
- `out_last`  out  1  current beat is the final one of the dump.
- `busy`  out  1  high in RUN and DONE.
- `done`  out  1  one-cycle pulse on normal completion.

## Operation
- The block has three states: IDLE, RUN and DONE.
- Internal state:
  - `ptr` (AW bits): next index to read.
  - `remaining` (AW+1 bits): number of beats not yet loaded.
  - Output register holding `out_valid`, `out_addr`, `out_data` and `out_last`.
- IDLE:
  - `busy` is 0.
  - On `start`: `ptr` <= `first_reg`; `remaining` <= ((`last_reg` - `first_reg`) mod NREGS) + 1; go to RUN.
  - `first_reg` > `last_reg` means a wrapping range, e.g. 30..1 gives 30, 31, 0, 1.
  - `first_reg` == `last_reg` gives exactly one beat.
  - `remaining` ranges over 1..NREGS; a full dump is never expressible as 0.
- RUN:
  - `ra` = `ptr` (combinational).
  - Load condition: `remaining` != 0 and (`out_valid` == 0 or `out_ready` == 1).
  - On load:
    - `out_data` <= `rd`; `out_addr` <= `ptr`; `out_last` <= (`remaining` == 1); `out_valid` <= 1.
    - `ptr` <= `ptr` + 1, wrapping NREGS-1 -> 0.
    - `remaining` <= `remaining` - 1.
  - If `out_valid` && `out_ready` with no load that cycle: `out_valid` <= 0.
  - If `out_valid` && `out_ready` && `out_last`: go to DONE; `out_valid` <= 0.
  - `abort` (priority over all RUN actions): `out_valid` <= 0; go to IDLE; no `done` pulse. A beat handshaken in the same cycle as `abort` counts as delivered.
- DONE: `done` = 1 for exactly one cycle, then IDLE.
- `start` outside IDLE and `abort` outside RUN are ignored.
- While valid and not ready, `out_addr`, `out_data` and `out_last` are held stable.
- `rd` is sampled at the load edge. A register-file write committing on the same edge is not visible; the beat carries the pre-write value. There is no bypass.
- Index 0 is read like any other; the register file returns 0.
- When not in RUN, `ra` drives 0.

## Timing
- Reset values: state IDLE, `out_valid` 0, `out_last` 0, `out_addr` 0, `out_data` 0, `busy` 0, `done` 0, `ptr` 0, `remaining` 0.
- `rst` mid-dump returns to the reset values on that edge; no `done` pulse.
- Sequence with `start` sampled at edge E0:
  - After E0: `busy` = 1 and RUN.
  - At E1: first load; `out_valid` is visible after E1.
- Throughput: one beat per cycle when `out_ready` is held high.
- With `out_ready` held high, a dump of N registers is:
  - N consecutive valid cycles, starting the cycle after E1.
  - `done` high the cycle after the final handshake.
  - `busy` low the cycle after that.
- Every output is registered except `ra`, which is combinational from `ptr` and state.

## Test plan
- Full dump: preload reg i = i*3 (reg 0 = 0); `first_reg`=0, `last_reg`=31, `out_ready`=1.
  - Required: 32 back-to-back beats with `out_addr` 0..31 and `out_data` = i*3 (reg 0 reads 0).
  - `out_last` set only on index 31; `done` 1 cycle after beat 31; 35 cycles from `start` to `busy`=0.
- Wrap range: `first_reg`=30, `last_reg`=1 -> beats with `out_addr` 30, 31, 0, 1; `out_last` set on 1.
- Single register: `first_reg`=`last_reg`=5, reg5 = 32'hDEADBEEF -> one beat with `out_last`=1 and `out_data` = 32'hDEADBEEF.
- Backpressure: `out_ready` = 1,0,0,1,0,1,... with a pseudo-random pattern.
  - Each beat's `out_addr`, `out_data` and `out_last` are stable while stalled.
  - No index is skipped or duplicated; `done` follows the last handshake.
- Disruptions:
  - `start` pulsed during RUN is ignored.
  - `abort` at beat 4 -> `out_valid` 0 next cycle, IDLE, no `done`.
  - `rst` at beat 10 of a new dump -> all outputs return to their reset values next cycle.
- Write collision: write reg7 = 7 -> 99 on the same edge as the load of index 7 -> the beat for index 7 carries 7.

Source files
------------

// File: rtl/regfile_dump_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : regfile_dump_ctrl
// Purpose  : Walks an inclusive, optionally wrapping range of register-file
//            indices through one async read port and streams (index, data)
//            beats out over a valid/ready handshake.
// Revision : 1.0 - initial release
// ============================================================================
module regfile_dump_ctrl #(
    parameter int NREGS = 32,
    parameter int AW    = 5,
    parameter int DW    = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          abort,
    input  logic [AW-1:0] first_reg,
    input  logic [AW-1:0] last_reg,
    output logic [AW-1:0] ra,
    input  logic [DW-1:0] rd,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [AW-1:0] out_addr,
    output logic [DW-1:0] out_data,
    output logic          out_last,
    output logic          busy,
    output logic          done
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [AW:0]   C_ONE      = (AW+1)'(1);
    localparam logic [AW-1:0] C_LAST_IDX = AW'(NREGS - 1);

    state_t        r_state;
    logic [AW-1:0] r_ptr;
    logic [AW:0]   r_remaining;
    logic          r_out_valid;
    logic [AW-1:0] r_out_addr;
    logic [DW-1:0] r_out_data;
    logic          r_out_last;
    logic          r_busy;
    logic          r_done;

    logic [AW-1:0] w_span;
    logic          w_load;
    logic          w_handshake;

    // Range length minus one; AW-bit subtraction gives the wrap for free.
    assign w_span      = last_reg - first_reg;
    assign w_load      = (r_remaining != '0) && (!r_out_valid || out_ready);
    assign w_handshake = r_out_valid && out_ready;

    assign ra        = (r_state == S_RUN) ? r_ptr : '0;
    assign out_valid = r_out_valid;
    assign out_addr  = r_out_addr;
    assign out_data  = r_out_data;
    assign out_last  = r_out_last;
    assign busy      = r_busy;
    assign done      = r_done;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_ptr       <= '0;
            r_remaining <= '0;
            r_out_valid <= 1'b0;
            r_out_addr  <= '0;
            r_out_data  <= '0;
            r_out_last  <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        r_ptr       <= first_reg;
                        r_remaining <= {1'b0, w_span} + C_ONE;
                        r_busy      <= 1'b1;
                        r_state     <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (abort) begin
                        r_out_valid <= 1'b0;
                        r_busy      <= 1'b0;
                        r_state     <= S_IDLE;
                    end else begin
                        if (w_load) begin
                            r_out_data  <= rd;
                            r_out_addr  <= r_ptr;
                            r_out_last  <= (r_remaining == C_ONE);
                            r_out_valid <= 1'b1;
                            r_ptr       <= (r_ptr == C_LAST_IDX) ? '0 : r_ptr + AW'(1);
                            r_remaining <= r_remaining - C_ONE;
                        end else if (w_handshake) begin
                            r_out_valid <= 1'b0;
                        end
                        // Final beat accepted: remaining is already 0, so no load collides here.
                        if (w_handshake && r_out_last) begin
                            r_out_valid <= 1'b0;
                            r_done      <= 1'b1;
                            r_state     <= S_DONE;
                        end
                    end
                end
                S_DONE: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_regfile_dump_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_regfile_dump_ctrl
// Purpose  : Self-checking bench for regfile_dump_ctrl against a queue-based
//            model of the expected beat stream.
// Revision : 1.0 - initial release
// ============================================================================
module tb_regfile_dump_ctrl;

    localparam int NREGS = 32;
    localparam int AW    = 5;
    localparam int DW    = 32;
    localparam int BOUND = 2000;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          abort;
    logic [AW-1:0] first_reg;
    logic [AW-1:0] last_reg;
    logic [AW-1:0] ra;
    logic [DW-1:0] rd;
    logic          out_valid;
    logic          out_ready;
    logic [AW-1:0] out_addr;
    logic [DW-1:0] out_data;
    logic          out_last;
    logic          busy;
    logic          done;

    logic [DW-1:0] regs [NREGS];
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    assign rd = (ra == '0) ? '0 : regs[ra];

    always @(posedge clk) begin
        if (wr_en && wr_addr != '0) regs[wr_addr] <= wr_data;
    end

    regfile_dump_ctrl #(.NREGS(NREGS), .AW(AW), .DW(DW)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .first_reg(first_reg), .last_reg(last_reg),
        .ra(ra), .rd(rd),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_addr(out_addr), .out_data(out_data), .out_last(out_last),
        .busy(busy), .done(done)
    );

    function automatic logic [DW-1:0] model_rd(input logic [AW-1:0] idx);
        return (idx == '0) ? '0 : regs[idx];
    endfunction

    // mode 0: i*3, mode 1: i, mode 2: random
    task automatic preload(input int mode);
        for (int i = 1; i < NREGS; i++) begin
            @(negedge clk);
            wr_en   = 1'b1;
            wr_addr = AW'(i);
            wr_data = (mode == 0) ? DW'(i * 3) : (mode == 1) ? DW'(i) : DW'($urandom);
        end
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic write_one(input logic [AW-1:0] a, input logic [DW-1:0] d);
        @(negedge clk);
        wr_en = 1'b1; wr_addr = a; wr_data = d;
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic pulse_start(input logic [AW-1:0] f, input logic [AW-1:0] l);
        @(negedge clk);
        first_reg = f; last_reg = l; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic run_dump(input logic [AW-1:0] f, input logic [AW-1:0] l,
                            input bit rand_ready, input bit collide, input bit poke_start);
        logic [AW-1:0] exp_a[$];
        logic [DW-1:0] exp_d[$];
        bit            exp_l[$];
        logic [AW-1:0] span, idx, p_addr;
        logic [DW-1:0] p_data;
        bit            p_v, p_r, p_last, collided;
        int n, iter, last_hs, first_v, v_cycles, done_seen, end_iter;

        span = l - f;
        n = int'(span) + 1;
        for (int k = 0; k < n; k++) begin
            idx = f + AW'(k);
            exp_a.push_back(idx);
            exp_d.push_back(model_rd(idx));
            exp_l.push_back(k == n - 1);
        end
        p_v = 0; p_r = 0; p_addr = '0; p_data = '0; p_last = 0; collided = 0;
        last_hs = -10; first_v = -1; v_cycles = 0; done_seen = 0; end_iter = -1;

        out_ready = 1'b1;
        pulse_start(f, l);
        checks++;
        if (busy !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL start_state busy=%b out_valid=%b required busy=1 out_valid=0", busy, out_valid);
        end

        for (iter = 0; iter < BOUND; iter++) begin
            out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            start     = (poke_start && iter == 3);
            if (poke_start && iter == 3) begin
                first_reg = 5'd20; last_reg = 5'd21;
            end
            if (collide && !collided && busy && ra == 5'd7) begin
                wr_en = 1'b1; wr_addr = 5'd7; wr_data = 32'd99; collided = 1;
            end else begin
                wr_en = 1'b0;
            end

            if (p_v && !p_r) begin
                checks++;
                if (out_valid !== 1'b1 || out_addr !== p_addr || out_data !== p_data || out_last !== p_last) begin
                    errors++;
                    $display("FAIL stall_hold v=%b addr=%0d data=%h last=%b required v=1 addr=%0d data=%h last=%b",
                             out_valid, out_addr, out_data, out_last, p_addr, p_data, p_last);
                end
            end
            if (done === 1'b1) begin
                done_seen++;
                checks++;
                if (last_hs != iter - 1) begin
                    errors++;
                    $display("FAIL done_timing done at iter %0d required iter %0d", iter, last_hs + 1);
                end
            end
            if (out_valid === 1'b1) begin
                v_cycles++;
                if (first_v < 0) first_v = iter;
            end
            if (out_valid === 1'b1 && out_ready) begin
                checks++;
                if (exp_a.size() == 0) begin
                    errors++;
                    $display("FAIL extra_beat addr=%0d required no beat", out_addr);
                end else begin
                    if (out_addr !== exp_a[0] || out_data !== exp_d[0] || out_last !== exp_l[0]) begin
                        errors++;
                        $display("FAIL beat addr=%0d data=%h last=%b required addr=%0d data=%h last=%b",
                                 out_addr, out_data, out_last, exp_a[0], exp_d[0], exp_l[0]);
                    end
                    if (exp_l[0]) last_hs = iter;
                    void'(exp_a.pop_front()); void'(exp_d.pop_front()); void'(exp_l.pop_front());
                end
            end
            if (busy === 1'b0) begin
                end_iter = iter;
                break;
            end
            p_v = out_valid; p_r = out_ready; p_addr = out_addr; p_data = out_data; p_last = out_last;
            @(negedge clk);
        end
        start = 1'b0; wr_en = 1'b0;

        checks++;
        if (end_iter < 0) begin
            errors++;
            $display("FAIL timeout busy still %b after %0d cycles required 0", busy, BOUND);
        end
        checks++;
        if (exp_a.size() != 0) begin
            errors++;
            $display("FAIL missing_beats left=%0d required 0", exp_a.size());
        end
        checks++;
        if (done_seen != 1) begin
            errors++;
            $display("FAIL done_count got=%0d required 1", done_seen);
        end
        checks++;
        if (end_iter != last_hs + 2) begin
            errors++;
            $display("FAIL busy_drop iter=%0d required %0d", end_iter, last_hs + 2);
        end
        if (!rand_ready) begin
            checks++;
            if (first_v != 1 || v_cycles != n || end_iter != n + 2) begin
                errors++;
                $display("FAIL stream_timing first_valid=%0d valid_cycles=%0d busy_low=%0d required 1 %0d %0d",
                         first_v, v_cycles, end_iter, n, n + 2);
            end
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (out_valid !== 0 || out_last !== 0 || out_addr !== '0 || out_data !== '0 ||
            busy !== 0 || done !== 0 || ra !== '0) begin
            errors++;
            $display("FAIL reset_values v=%b last=%b addr=%0d data=%h busy=%b done=%b ra=%0d required all 0",
                     out_valid, out_last, out_addr, out_data, busy, done, ra);
        end
        rst = 1'b0;
    endtask

    task automatic test_full_dump;
        preload(0);
        run_dump(5'd0, 5'd31, 0, 0, 0);
    endtask

    task automatic test_wrap;
        run_dump(5'd30, 5'd1, 0, 0, 0);
    endtask

    task automatic test_single;
        write_one(5'd5, 32'hDEADBEEF);
        run_dump(5'd5, 5'd5, 0, 0, 0);
    endtask

    task automatic test_backpressure;
        preload(0);
        run_dump(5'd3, 5'd20, 1, 0, 0);
        run_dump(5'd28, 5'd4, 1, 0, 0);
    endtask

    task automatic test_start_ignored;
        run_dump(5'd0, 5'd31, 0, 0, 1);
    endtask

    task automatic test_abort;
        int hs, iter;
        bit fired;
        hs = 0; fired = 0;
        out_ready = 1'b1;
        pulse_start(5'd0, 5'd31);
        for (iter = 0; iter < BOUND && !fired; iter++) begin
            if (out_valid === 1'b1 && hs == 4) begin
                abort = 1'b1;
                fired = 1;
                checks++;
                if (out_addr !== 5'd4) begin
                    errors++;
                    $display("FAIL abort_beat addr=%0d required 4", out_addr);
                end
            end else if (out_valid === 1'b1) begin
                hs++;
            end
            @(negedge clk);
        end
        abort = 1'b0;
        checks++;
        if (!fired || out_valid !== 0 || busy !== 0 || done !== 0) begin
            errors++;
            $display("FAIL abort_state fired=%b v=%b busy=%b done=%b required 1 0 0 0",
                     fired, out_valid, busy, done);
        end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++;
            if (done !== 0 || busy !== 0 || out_valid !== 0) begin
                errors++;
                $display("FAIL abort_quiet done=%b busy=%b v=%b required 0 0 0", done, busy, out_valid);
            end
        end
    endtask

    task automatic test_mid_reset;
        int hs, iter;
        bit fired;
        hs = 0; fired = 0;
        out_ready = 1'b1;
        pulse_start(5'd0, 5'd31);
        for (iter = 0; iter < BOUND && !fired; iter++) begin
            if (out_valid === 1'b1 && hs == 10) begin
                rst = 1'b1;
                fired = 1;
            end else if (out_valid === 1'b1) begin
                hs++;
            end
            @(negedge clk);
        end
        rst = 1'b0;
        checks++;
        if (!fired || out_valid !== 0 || out_last !== 0 || out_addr !== '0 || out_data !== '0 ||
            busy !== 0 || done !== 0 || ra !== '0) begin
            errors++;
            $display("FAIL mid_reset fired=%b v=%b last=%b addr=%0d data=%h busy=%b done=%b ra=%0d required 1 and all 0",
                     fired, out_valid, out_last, out_addr, out_data, busy, done, ra);
        end
        @(negedge clk);
        checks++;
        if (done !== 0 || busy !== 0) begin
            errors++;
            $display("FAIL mid_reset_quiet done=%b busy=%b required 0 0", done, busy);
        end
    endtask

    task automatic test_collision;
        preload(1);
        run_dump(5'd5, 5'd9, 0, 1, 0);
        checks++;
        if (regs[7] !== 32'd99) begin
            errors++;
            $display("FAIL collide_write reg7=%0d required 99", regs[7]);
        end
    endtask

    task automatic test_random;
        logic [AW-1:0] f, l;
        for (int t = 0; t < 6; t++) begin
            preload(2);
            f = AW'($urandom);
            l = AW'($urandom);
            run_dump(f, l, 1, 0, 0);
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; abort = 1'b0; out_ready = 1'b0;
        first_reg = '0; last_reg = '0;
        wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        test_reset();
        test_full_dump();
        test_wrap();
        test_single();
        test_backpressure();
        test_start_ignored();
        test_abort();
        test_mid_reset();
        test_collision();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        if (errors == 0)
            $display("PASS");
        else
            $display("FAIL");
        $finish;
    end

endmodule
`default_nettype wire
